ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter that shares one single-port synchronous-read RAM (single address bus, separate din/dout, write enable, read address latched on the clock edge) between two masters. Each requester issues single-beat reads or writes through a req/gnt handshake, and read data is returned with a per-requester valid strobe one cycle later. Fairness is round-robin, with bounded burst ownership. The block sits between the RAM instance and its two client engines.

## Interface
- AWIDTH, 3: address width; must match the RAM.
- DWIDTH, 32: data width; must match the RAM.
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is waiting. Must be ≥1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read; valid with req.
- addr0 / addr1  in  AWIDTH  access address.
- din0 / din1  in  DWIDTH  write data.
- gnt0 / gnt1  out  1  combinational; access accepted this cycle.
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle.
- rdata0 / rdata1  out  DWIDTH  both driven from ram_dout; meaningful only while the matching rvalid is high.
- ram_addr  out  AWIDTH  to the RAM addr input.
- ram_din  out  DWIDTH  to the RAM din input.
- ram_we  out  1  to the RAM we input.
- ram_dout  in  DWIDTH  from the RAM dout output.

## Operation
FSM states:
- IDLE: no current owner.
- OWN0: requester 0 owns the port.
- OWN1: requester 1 owns the port.

Registers:
- state
- rr_last: last served requester, 1 bit.
- beat_cnt: consecutive grants to the current owner, width clog2(MAX_BURST)+1.
- rvalid0_q, rvalid1_q

Grant decision (combinational, evaluated each cycle):
- IDLE, single requester: grant that requester.
- IDLE, both requesting: grant the requester ≠ rr_last.
- OWNi, req_i high, other requester idle or beat_cnt < MAX_BURST: grant i.
- OWNi, other requester high, and either req_i low or beat_cnt = MAX_BURST: grant the other requester.
- No request: no grant.

Next-state rules:
- Grant to the same owner: stay in OWNi, beat_cnt += 1, saturating at MAX_BURST.
- Grant to a new owner: move to OWNj, beat_cnt = 1, rr_last = j.
- No grant: go to IDLE, beat_cnt = 0.

Datapath:
- ram_addr, ram_din and ram_we are muxed from the granted requester.
- With no grant: ram_we = 0, and ram_addr/ram_din hold the requester-0 values. These are don't-care, but must be deterministic.
- Granted read (gnt_i & ~we_i): rvalid_i_q is set for the next cycle.
- Granted write: drives ram_we = 1 and produces no rvalid.

Reset (while reset is high):
- gnt0, gnt1 and ram_we are forced to 0 combinationally.
- At the edge: state = IDLE, rr_last = 1 (requester 0 has first priority), beat_cnt = 0, rvalid0/1 = 0.
- Reset during the cycle after a granted read: rvalid stays high for that cycle, since it is already registered, and clears at the edge.

## Timing
- Throughput: one access per cycle. There is no turnaround bubble on an owner switch.
- Read latency: gnt in cycle T → rvalid_i and rdata_i = mem[addr] in cycle T+1.
- Write: memory is updated at the end of cycle T. A read of the same address granted in T+1 returns the new data.
- Back-to-back reads from alternating requesters each return on their own rvalid. The two rvalids are never high together.
- gnt depends combinationally on req, we is not involved, and the outputs have no combinational path from ram_dout except rdata.
- Requester obligation: req, we, addr and din stay stable until the cycle in which gnt is seen.

## Structure
- Shared package ram_arb_pkg holds:
  - the state enum {ARB_IDLE, ARB_OWN0, ARB_OWN1}
  - the default MAX_BURST constant
  - a function computing the beat_cnt width
- A single module is sufficient; no sub-module is needed. The RAM itself is instantiated by the parent and is not inside this block.

## Test plan
- Reset, then req0 write addr 2 din 0xA5A5_0001, then req0 read addr 2 → gnt0 in both cycles; rvalid0 = 1 with rdata0 = 0xA5A5_0001 one cycle after the read grant; rvalid1 never asserts.
- Both requesters request reads in the first cycle after reset (req0 addr 1, req1 addr 3) → gnt0 first (rr_last = 1 from reset), gnt1 next cycle; rvalid0 then rvalid1 on consecutive cycles.
- req0 held high continuously with MAX_BURST = 4, req1 asserted from cycle 0 → grant pattern 0,0,0,0,1,0,0,0,0,1…
- req1 alone for 6 cycles → gnt1 every cycle; beat_cnt saturates; no stall; state remains OWN1.
- Write addr 5 = 0x1234 by req0 in cycle T, read addr 5 by req1 in T+1 → rdata1 = 0x1234 at T+2.
- Read granted in T, reset high in T+1 with both reqs high → rvalid high in T+1, then gnt0/1 = 0 and ram_we = 0 during reset; after release, requester 0 is served first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and sizing helpers for ram_port_arbiter
package ram_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_e;
  localparam int DEFAULT_MAX_BURST = 4;
  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction
endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin, burst-bounded sharing of one sync-read RAM port between two requesters
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AWIDTH    = 3,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] din0,
  input  logic [DWIDTH-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);
  localparam int BW = beat_cnt_width(MAX_BURST);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);
  arb_state_e state_q, state_d;
  logic rr_last_q, rr_last_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic full, pick0, same;
  // pick0 says whether requester 0 wins when it is requesting
  always_comb begin
    full = beat_cnt_q == BEAT_MAX;
    pick0 = state_q == ARB_IDLE ? (~req1 | rr_last_q) :
            state_q == ARB_OWN0 ? (~req1 | ~full) : (~req1 | full);
    gnt0 = ~reset & req0 & pick0;
    gnt1 = ~reset & req1 & ~(req0 & pick0);
    same = (gnt0 & state_q == ARB_OWN0) | (gnt1 & state_q == ARB_OWN1);
    state_d = gnt0 ? ARB_OWN0 : gnt1 ? ARB_OWN1 : ARB_IDLE;
    rr_last_d = gnt0 | gnt1 ? gnt1 : rr_last_q;
    beat_cnt_d = ~(gnt0 | gnt1) ? '0 : ~same ? BW'(1) : full ? beat_cnt_q : beat_cnt_q + 1'b1;
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    ram_addr = gnt1 ? addr1 : addr0;
    ram_din = gnt1 ? din1 : din0;
    ram_we = gnt0 ? we0 : gnt1 & we1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      rr_last_q <= 1'b1;
      beat_cnt_q <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_last_q <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0 = ram_dout;
  assign rdata1 = ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of ram_port_arbiter against a request-level reference model
module tb_ram_port_arbiter;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int MB = 4;
  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [DW-1:0] din0 = 0, din1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  ram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );
  logic [DW-1:0] ram [8];
  always @(posedge clock) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end
  int total = 0, bad = 0;
  int m_owner = -1, m_cnt = 0, m_last = 1;
  logic m_rv0 = 0, m_rv1 = 0;
  logic [DW-1:0] m_rd = 0;
  logic [DW-1:0] m_mem [8];
  logic g0s = 0, g1s = 0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // who the rules say should win this cycle: -1 none, 0 or 1
  function automatic int exp_grant();
    if (reset || (!req0 && !req1)) return -1;
    if (req0 && !req1) return 0;
    if (req1 && !req0) return 1;
    if (m_owner < 0) return 1 - m_last;
    return (m_cnt >= MB) ? 1 - m_owner : m_owner;
  endfunction
  task automatic step();
    int e;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #4;
    e = exp_grant();
    w = (e == 0) ? we0 : (e == 1) ? we1 : 1'b0;
    a = (e == 1) ? addr1 : addr0;
    d = (e == 1) ? din1 : din0;
    chk("gnt0", DW'(gnt0), DW'(e == 0));
    chk("gnt1", DW'(gnt1), DW'(e == 1));
    chk("ram_we", DW'(ram_we), DW'(w));
    chk("ram_addr", DW'(ram_addr), DW'(a));
    chk("ram_din", ram_din, d);
    chk("rvalid0", DW'(rvalid0), DW'(m_rv0));
    chk("rvalid1", DW'(rvalid1), DW'(m_rv1));
    if (m_rv0) chk("rdata0", rdata0, m_rd);
    if (m_rv1) chk("rdata1", rdata1, m_rd);
    g0s = gnt0;
    g1s = gnt1;
    @(posedge clock);
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
    end else begin
      m_rv0 = (e == 0) && !we0;
      m_rv1 = (e == 1) && !we1;
      if (e >= 0) begin
        m_rd = m_mem[a];
        if (w) m_mem[a] = d;
        m_cnt = (e == m_owner) ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : 1;
        m_owner = e;
        m_last = e;
      end else begin
        m_owner = -1;
        m_cnt = 0;
      end
    end
    #1;
  endtask
  task automatic drive(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    step();
    reset = 0;
  endtask
  logic p0 = 0, p1 = 0;
  initial begin
    @(posedge clock);
    #1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, AW'(i), $urandom, 0, 0, 0, 0);
      step();
    end
    // single-requester write then read-back
    drive(1, 1, 2, 32'hA5A5_0001, 0, 0, 0, 0);
    step();
    chk("t1_wr_gnt", DW'(g0s), 1);
    drive(1, 0, 2, 0, 0, 0, 0, 0);
    step();
    chk("t1_rd_gnt", DW'(g0s), 1);
    chk("t1_rdata0", rdata0, 32'hA5A5_0001);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // both request straight after reset: requester 0 first
    do_reset();
    drive(1, 0, 1, 0, 1, 0, 3, 0);
    step();
    chk("t2_first", DW'(g0s), 1);
    drive(0, 0, 0, 0, 1, 0, 3, 0);
    step();
    chk("t2_second", DW'(g1s), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // burst bound: req0 always, req1 re-requests one cycle after each grant
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1, 0, AW'(k), 0, !g1s || k == 0, 0, AW'(7 - k), 0);
      step();
      chk("t3_burst", DW'(g1s), DW'(k % 5 == 4));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // lone requester 1 streams without stalling
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 1, 0, AW'(k), 0);
      step();
      chk("t4_lone", DW'(g1s), 1);
    end
    // write by 0 then read of same address by 1
    drive(1, 1, 5, 32'h1234, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 5, 0);
    step();
    chk("t5_rdata1", rdata1, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // reset in the cycle after a read grant
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 4, 0, 1, 1, 6, 32'hdead);
    reset = 1;
    step();
    reset = 0;
    step();
    chk("t6_after_rst", DW'(g0s), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // random traffic, each request held until granted
    for (int k = 0; k < 400; k++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; we0 = 1'($urandom); addr0 = AW'($urandom); din0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; we1 = 1'($urandom); addr1 = AW'($urandom); din1 = $urandom;
      end
      req0 = p0;
      req1 = p1;
      reset = ($urandom_range(0, 39) == 0);
      step();
      if (g0s) p0 = 0;
      if (g1s) p1 = 0;
    end
    reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
